// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, shift-control and FSM encodings for the ALU arbiter
package alu_pkg;

    localparam logic [3:0] OP_ADD       = 4'd0;
    localparam logic [3:0] OP_SUB       = 4'd1;
    localparam logic [3:0] OP_MUL       = 4'd2;
    localparam logic [3:0] OP_OR        = 4'd3;
    localparam logic [3:0] OP_AND       = 4'd4;
    localparam logic [3:0] OP_XOR       = 4'd5;
    localparam logic [3:0] OP_MAX_VALID = 4'd5;

    localparam logic [2:0] SR_NONE  = 3'b000;
    localparam logic [2:0] SR_RIGHT = 3'b001;
    localparam logic [2:0] SR_LEFT  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_simple.sv
// rtl/alu_simple.sv - combinational 32-bit ALU with pre-shift of operand B
// Ports: In1/In2 operands, opcode, SR_Bit shift amount, SR_Cont shift control, Out result.
module alu_simple
    import alu_pkg::*;
(
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    input  logic [3:0]  opcode,
    input  logic [4:0]  SR_Bit,
    input  logic [2:0]  SR_Cont,
    output logic [31:0] Out
);

    logic [31:0] b_shifted;

    // Operand B is shifted before the operation; unknown shift codes pass B through.
    always_comb begin
        b_shifted = In2;
        case (SR_Cont)
            SR_RIGHT: b_shifted = In2 >> SR_Bit;
            SR_LEFT:  b_shifted = In2 << SR_Bit;
            default:  b_shifted = In2;
        endcase
    end

    // All results are truncated to 32 bits, so overflow wraps modulo 2^32.
    always_comb begin
        Out = 32'd0;
        case (opcode)
            OP_ADD:  Out = In1 + b_shifted;
            OP_SUB:  Out = In1 - b_shifted;
            OP_MUL:  Out = In1 * b_shifted;
            OP_OR:   Out = In1 | b_shifted;
            OP_AND:  Out = In1 & b_shifted;
            OP_XOR:  Out = In1 ^ b_shifted;
            default: Out = 32'd0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
// Ports: req request vector, last previous winner, gnt one-hot grant, gnt_id winner index, any.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    any
);

    localparam int ID_W = $clog2(NREQ);

    // Scan last+1, last+2, ... wrapping, so last itself is checked last of all.
    always_comb begin
        int idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one alu_simple among NREQ requesters
// Ports: clk, rst (async, active high); req_valid/req_ready handshake with packed
// per-requester In1/In2/opcode/SR_Bit/SR_Cont fields; resp_valid/resp_ready handshake
// carrying resp_Out, resp_id and resp_err; busy while an operation is in flight.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*32-1:0]      req_In1,
    input  logic [NREQ*32-1:0]      req_In2,
    input  logic [NREQ*4-1:0]       req_opcode,
    input  logic [NREQ*5-1:0]       req_SR_Bit,
    input  logic [NREQ*3-1:0]       req_SR_Cont,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_Out,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int ID_W = $clog2(NREQ);

    state_t state_q, state_d;

    logic [31:0]     in1_q, in2_q;
    logic [3:0]      opcode_q;
    logic [4:0]      sr_bit_q;
    logic [2:0]      sr_cont_q;
    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] resp_id_q;
    logic [31:0]     resp_out_q;
    logic            resp_err_q;
    logic            resp_valid_q;

    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic [31:0]     alu_out;
    logic            op_invalid;

    logic [31:0] in1_a     [NREQ];
    logic [31:0] in2_a     [NREQ];
    logic [3:0]  opcode_a  [NREQ];
    logic [4:0]  sr_bit_a  [NREQ];
    logic [2:0]  sr_cont_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign in1_a[g]     = req_In1[32*g +: 32];
        assign in2_a[g]     = req_In2[32*g +: 32];
        assign opcode_a[g]  = req_opcode[4*g +: 4];
        assign sr_bit_a[g]  = req_SR_Bit[5*g +: 5];
        assign sr_cont_a[g] = req_SR_Cont[3*g +: 3];
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req    (req_valid),
        .last   (last_grant_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (gnt_any)
    );

    alu_simple u_alu (
        .In1     (in1_q),
        .In2     (in2_q),
        .opcode  (opcode_q),
        .SR_Bit  (sr_bit_q),
        .SR_Cont (sr_cont_q),
        .Out     (alu_out)
    );

    assign op_invalid = (opcode_q > OP_MAX_VALID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants are only offered from IDLE; resp_ready never feeds this path.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_q == IDLE) begin
            req_ready = gnt;
        end else begin
            busy = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in1_q        <= '0;
            in2_q        <= '0;
            opcode_q     <= '0;
            sr_bit_q     <= '0;
            sr_cont_q    <= '0;
            last_grant_q <= ID_W'(NREQ - 1);
            resp_id_q    <= '0;
            resp_out_q   <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        in1_q        <= in1_a[gnt_id];
                        in2_q        <= in2_a[gnt_id];
                        opcode_q     <= opcode_a[gnt_id];
                        sr_bit_q     <= sr_bit_a[gnt_id];
                        sr_cont_q    <= sr_cont_a[gnt_id];
                        last_grant_q <= gnt_id;
                        resp_id_q    <= gnt_id;
                    end
                end
                EXEC: begin
                    resp_out_q   <= op_invalid ? 32'd0 : alu_out;
                    resp_err_q   <= op_invalid;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_Out   = resp_out_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed vector bench for alu_arbiter
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_In1;
    logic [NREQ*32-1:0]   req_In2;
    logic [NREQ*4-1:0]    req_opcode;
    logic [NREQ*5-1:0]    req_SR_Bit;
    logic [NREQ*3-1:0]    req_SR_Cont;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_Out;
    logic [ID_W-1:0]      resp_id;
    logic                 resp_err;
    logic                 busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_In1     (req_In1),
        .req_In2     (req_In2),
        .req_opcode  (req_opcode),
        .req_SR_Bit  (req_SR_Bit),
        .req_SR_Cont (req_SR_Cont),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_Out    (resp_Out),
        .resp_id     (resp_id),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sb;
        logic [2:0]  sc;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] sb, input logic [2:0] sc);
        req_In1[32*i +: 32]    = a;
        req_In2[32*i +: 32]    = b;
        req_opcode[4*i +: 4]   = op;
        req_SR_Bit[5*i +: 5]   = sb;
        req_SR_Cont[3*i +: 3]  = sc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int waited;
        @(negedge clk);
        set_fields(v.id, v.op, v.a, v.b, v.sb, v.sc);
        req_valid = NREQ'(1) << v.id;
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("req_ready", 32'(req_ready), 32'(NREQ'(1) << v.id));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("exec_valid", 32'(resp_valid), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_Out", resp_Out, v.exp_out);
        check("resp_id", 32'(resp_id), 32'(v.id));
        check("resp_err", 32'(resp_err), 32'(v.exp_err));
        @(negedge clk);
        check("done_valid", 32'(resp_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] rr_exp [4];
        int grants [$];
        logic [31:0] r_out [$];
        int r_id [$];
        int cyc;
        logic [31:0] held_out;
        logic [ID_W-1:0] held_id;

        vecs[0] = '{2, 4'd0, 32'd15,      32'd20,      5'd0, 3'b000, 32'd35,         1'b0};
        vecs[1] = '{0, 4'd0, 32'd30,      32'd10,      5'd4, 3'b010, 32'd190,        1'b0};
        vecs[2] = '{1, 4'd0, 32'd30,      32'd10,      5'd4, 3'b001, 32'd30,         1'b0};
        vecs[3] = '{3, 4'd9, 32'd5,       32'd7,       5'd0, 3'b000, 32'd0,          1'b1};
        vecs[4] = '{0, 4'd2, 32'h10000,   32'h10000,   5'd0, 3'b000, 32'd0,          1'b0};
        vecs[5] = '{1, 4'd1, 32'd5,       32'd7,       5'd0, 3'b000, 32'hFFFF_FFFE,  1'b0};
        vecs[6] = '{3, 4'd4, 32'hF0F0,    32'hFF00,    5'd0, 3'b000, 32'hF000,       1'b0};
        vecs[7] = '{2, 4'd5, 32'h0FF,     32'h0F0,     5'd0, 3'b000, 32'h00F,        1'b0};

        rst = 1'b1;
        req_valid = '0;
        req_In1 = '0;
        req_In2 = '0;
        req_opcode = '0;
        req_SR_Bit = '0;
        req_SR_Cont = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_out", resp_Out, 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Round-robin with all four requesting continuously.
        do_reset();
        rr_exp[0] = 32'd20; rr_exp[1] = 32'd25; rr_exp[2] = 32'h0A5; rr_exp[3] = 32'h00F;
        @(negedge clk);
        set_fields(0, 4'd1, 32'd30,   32'd10,   5'd0, 3'b000);
        set_fields(1, 4'd2, 32'd5,    32'd5,    5'd0, 3'b000);
        set_fields(2, 4'd3, 32'h0A0,  32'h005,  5'd0, 3'b000);
        set_fields(3, 4'd5, 32'h0FF,  32'h0F0,  5'd0, 3'b000);
        req_valid = 4'b1111;
        cyc = 0;
        while ((grants.size() < 5 || r_out.size() < 4) && cyc < 60) begin
            #1;
            for (int j = 0; j < NREQ; j++) if (req_ready[j]) grants.push_back(j);
            if (resp_valid) begin
                r_out.push_back(resp_Out);
                r_id.push_back(int'(resp_id));
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        check("rr_grants", 32'(grants.size()), 32'd5);
        check("rr_resps", 32'(r_out.size()), 32'd4);
        for (int k = 0; k < 5 && k < grants.size(); k++) check("rr_order", 32'(grants[k]), 32'(k % 4));
        for (int k = 0; k < 4 && k < r_out.size(); k++) begin
            check("rr_id", 32'(r_id[k]), 32'(k));
            check("rr_out", r_out[k], rr_exp[k]);
        end

        // Backpressure: hold RESP for 5 cycles while requester 3 waits.
        do_reset();
        resp_ready = 1'b0;
        @(negedge clk);
        set_fields(1, 4'd0, 32'd100, 32'd23, 5'd0, 3'b000);
        set_fields(3, 4'd0, 32'd1,   32'd1,  5'd0, 3'b000);
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = 4'b1000;
        cyc = 0;
        @(negedge clk);
        while (!resp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_valid", 32'(resp_valid), 32'd1);
        held_out = resp_Out;
        held_id = resp_id;
        check("bp_out", held_out, 32'd123);
        check("bp_id", 32'(held_id), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(resp_valid), 32'd1);
            check("bp_hold_out", resp_Out, 32'd123);
            check("bp_hold_id", 32'(resp_id), 32'd1);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_busy", 32'(busy), 32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_next_ready", 32'(req_ready), 32'b1000);
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset during EXEC after requester 1 was granted.
        do_reset();
        @(negedge clk);
        set_fields(1, 4'd0, 32'd1, 32'd2, 5'd0, 3'b000);
        req_valid = 4'b0010;
        #1;
        check("mr_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("mr_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(resp_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("mr_still_idle", 32'(resp_valid), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("mr_first_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
